// File: rtl/pc_fetch.sv
// pc_fetch: instruction-fetch stage feeding the IF/ID register.
// Owns the PC, issues word fetches over a req/ack bus, presents {if_pc, if_inst}
// or a zero bubble, and buffers a returned word while the pipeline is frozen.
// Optional build macro: IF_ALIGN_CHECK_EN (adds if_excp_adel, misaligned-PC check).
//
// state | meaning
// IDLE  | one dead cycle after reset, no request, bubble out
// REQ   | request outstanding at pc; word presented in the ack cycle
// HOLD  | word returned while frozen; re-presented from buffer, no request
module pc_fetch #(
   parameter int          ADDR_W   = 32,
   parameter int          INST_W   = 32,
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          PC_STEP  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [5:0]        stall,
   input  logic              branch_flag_i,
   input  logic [ADDR_W-1:0] branch_target_i,
   input  logic [INST_W-1:0] ibus_rdata,
   input  logic              ibus_ack,
   output logic              ibus_req,
   output logic [ADDR_W-1:0] ibus_addr,
   output logic [ADDR_W-1:0] if_pc,
   output logic [INST_W-1:0] if_inst,
`ifdef IF_ALIGN_CHECK_EN
   output logic              if_excp_adel,
`endif
   output logic              stallreq_if
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] next_pc;
   logic [ADDR_W-1:0] redirect_target;
   logic              redirect_pend;
   logic [INST_W-1:0] buffer;
   logic              advance;
   logic              word_ack;
   logic [INST_W-1:0] word_data;
   logic              misalign;
   logic              stop;

   assign stop = stall[0];

`ifdef IF_ALIGN_CHECK_EN
   logic excp_buf;
   // A misaligned PC in REQ is completed locally as a faulting "fetch"
   assign misalign  = (state == REQ) && (pc[1:0] != 2'b00);
   assign ibus_addr = pc;
`else
   assign misalign  = 1'b0;
   assign ibus_addr = {pc[ADDR_W-1:2], 2'b00};
`endif

   assign word_ack  = ibus_ack || misalign;
   assign word_data = misalign ? '0 : ibus_rdata;

   // Branch pulse wins over a pending redirect, which wins over sequential
   always_comb begin
      if (branch_flag_i)
         next_pc = branch_target_i;
      else if (redirect_pend)
         next_pc = redirect_target;
      else
         next_pc = pc + ADDR_W'(PC_STEP);
   end

   // Next state, PC-advance decision and presented outputs
   always_comb begin
      state_nxt   = state;
      advance     = 1'b0;
      ibus_req    = 1'b0;
      if_pc       = '0;
      if_inst     = '0;
      stallreq_if = 1'b0;
      case (state)
         IDLE: begin
            state_nxt = REQ;
         end
         REQ: begin
            ibus_req = !misalign;
            if (word_ack) begin
               if_pc   = pc;
               if_inst = word_data;
               if (stop)
                  state_nxt = HOLD;
               else
                  advance = 1'b1;
            end else begin
               stallreq_if = 1'b1;
            end
         end
         HOLD: begin
            if_pc   = pc;
            if_inst = buffer;
            if (!stop) begin
               advance   = 1'b1;
               state_nxt = REQ;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef IF_ALIGN_CHECK_EN
   // Fault flag follows the presented word, including its HOLD replay
   always_comb begin
      if_excp_adel = 1'b0;
      if (state == REQ)
         if_excp_adel = misalign;
      else if (state == HOLD)
         if_excp_adel = excp_buf;
   end

   // Remember whether the buffered word was a faulting one
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         excp_buf <= 1'b0;
      else if (state == REQ && word_ack && stop)
         excp_buf <= misalign;
   end
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // PC only moves on an advance edge, keeping ibus_addr stable until ack
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         pc <= RESET_PC[ADDR_W-1:0];
      else if (advance)
         pc <= next_pc;
   end

   // Capture the returned word when the pipeline is frozen in the ack cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         buffer <= '0;
      else if (state == REQ && word_ack && stop)
         buffer <= word_data;
   end

   // A branch seen while the PC is parked is remembered until the next advance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         redirect_pend   <= 1'b0;
         redirect_target <= '0;
      end else if (advance) begin
         redirect_pend   <= 1'b0;
      end else if (branch_flag_i) begin
         redirect_pend   <= 1'b1;
         redirect_target <= branch_target_i;
      end
   end

endmodule
